dcache_2way: RTL

- Parametrised 2-way set-associative, write-back, write-allocate data cache.
- Sits between the CPU load/store path and the 32-bit-block data memory, replacing the direct-mapped dcache.
- Adds per-set LRU replacement, width/depth parameters, and a flush mode that writes back every dirty line.

---
 rtl/dcache_2way_if.sv | 49 ++++
 rtl/dcache_2way.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_2way_if.sv
// Bus bundle for the 2-way data cache: CPU load/store port, flush control,
// block-wide memory port and a debug view of the controller state.
// slave  = the cache itself; master = the CPU/memory environment around it.
interface dcache_2way_if #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 2
);
  localparam int BLOCK_W = DATA_W << OFFSET_W;

  // CPU side
  logic                     C_READ;
  logic                     C_WRITE;
  logic [ADDR_W-1:0]        C_Address;
  logic [DATA_W-1:0]        C_WRITEDATA;
  logic [DATA_W-1:0]        C_READDATA;
  logic                     busywait;

  // flush control
  logic                     flush;
  logic                     flush_done;

  // memory side
  logic                     mem_read;
  logic                     mem_write;
  logic [ADDR_W-OFFSET_W-1:0] mem_address;
  logic [BLOCK_W-1:0]       mem_writedata;
  logic [BLOCK_W-1:0]       mem_readdata;
  logic                     mem_busywait;

  // controller state, for checkers and waveform debug
  logic [2:0]               dbg_state;

  modport slave (
    input  C_READ, C_WRITE, C_Address, C_WRITEDATA, flush,
    input  mem_readdata, mem_busywait,
    output C_READDATA, busywait, flush_done,
    output mem_read, mem_write, mem_address, mem_writedata,
    output dbg_state
  );

  modport master (
    output C_READ, C_WRITE, C_Address, C_WRITEDATA, flush,
    output mem_readdata, mem_busywait,
    input  C_READDATA, busywait, flush_done,
    input  mem_read, mem_write, mem_address, mem_writedata,
    input  dbg_state
  );
endinterface

// File: rtl/dcache_2way.sv
// 2-way set-associative, write-back, write-allocate data cache with per-set
// LRU replacement and a flush walk that writes back every dirty line.
//
// Handshakes: the CPU holds C_READ/C_WRITE (and address/data) until it sees
// busywait low; the access completes at that clock edge. The cache holds
// mem_read/mem_write, mem_address and mem_writedata stable until it sees
// mem_busywait low; the memory transfer completes at that clock edge and
// mem_readdata must still be valid during the following (FILL) cycle.
module dcache_2way #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 2
) (
  input  logic          clock,
  input  logic          reset,
  dcache_2way_if.slave  bus
);
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_W = DATA_W << OFFSET_W;
  localparam int SETS    = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WB         = 3'd1,
    FETCH      = 3'd2,
    FILL       = 3'd3,
    FLUSH_SCAN = 3'd4,
    FLUSH_WB   = 3'd5
  } state_t;

  state_t state_q, state_n;

  // line storage
  logic               valid_q [2][SETS];
  logic               dirty_q [2][SETS];
  logic               lru_q   [SETS];
  logic [TAG_W-1:0]   tag_q   [2][SETS];
  logic [BLOCK_W-1:0] data_q  [2][SETS];

  // miss victim and flush walk pointer ({set, way})
  logic               victim_q;
  logic [INDEX_W:0]   scan_q;

  // address decode
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag_in;
  logic [OFFSET_W-1:0] off;
  assign idx    = bus.C_Address[OFFSET_W +: INDEX_W];
  assign tag_in = bus.C_Address[ADDR_W-1 -: TAG_W];
  assign off    = bus.C_Address[OFFSET_W-1:0];

  logic hit0, hit1, hit, hit_way, req, victim_pick;
  logic [BLOCK_W-1:0] hit_block;
  logic [INDEX_W-1:0] scan_set;
  logic               scan_way, scan_last;

  assign hit0      = valid_q[0][idx] && (tag_q[0][idx] == tag_in);
  assign hit1      = valid_q[1][idx] && (tag_q[1][idx] == tag_in);
  assign hit       = hit0 | hit1;
  assign hit_way   = hit1;
  assign hit_block = hit_way ? data_q[1][idx] : data_q[0][idx];
  assign req       = bus.C_READ | bus.C_WRITE;
  // first invalid way wins (way0 preferred), otherwise the LRU way
  assign victim_pick = !valid_q[0][idx] ? 1'b0 :
                       !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  assign scan_set  = scan_q[INDEX_W:1];
  assign scan_way  = scan_q[0];
  assign scan_last = &scan_q;

  assign bus.C_READDATA = hit ? hit_block[off*DATA_W +: DATA_W] : '0;
  assign bus.dbg_state  = state_q;

  // control strobes decoded by the FSM
  logic hit_upd, fill_en, flush_clr, scan_inc, scan_clr, victim_ld;
  logic busy, mem_rd, mem_wr, done;
  logic [ADDR_W-OFFSET_W-1:0] maddr;
  logic [BLOCK_W-1:0]         mwdata;

  assign bus.busywait      = busy;
  assign bus.mem_read      = mem_rd;
  assign bus.mem_write     = mem_wr;
  assign bus.mem_address   = maddr;
  assign bus.mem_writedata = mwdata;
  assign bus.flush_done    = done;

  // next-state and output decode
  always_comb begin
    state_n   = state_q;
    busy      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    maddr     = '0;
    mwdata    = '0;
    done      = 1'b0;
    hit_upd   = 1'b0;
    fill_en   = 1'b0;
    flush_clr = 1'b0;
    scan_inc  = 1'b0;
    scan_clr  = 1'b0;
    victim_ld = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            hit_upd = 1'b1;
          end else begin
            busy      = 1'b1;
            victim_ld = 1'b1;
            state_n   = dirty_q[victim_pick][idx] ? WB : FETCH;
          end
        end else if (bus.flush) begin
          scan_clr = 1'b1;
          state_n  = FLUSH_SCAN;
        end
      end
      WB: begin
        busy   = 1'b1;
        mem_wr = 1'b1;
        maddr  = {tag_q[victim_q][idx], idx};
        mwdata = data_q[victim_q][idx];
        if (!bus.mem_busywait) state_n = FETCH;
      end
      FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        maddr  = {tag_in, idx};
        if (!bus.mem_busywait) state_n = FILL;
      end
      FILL: begin
        busy    = 1'b1;
        fill_en = 1'b1;
        state_n = IDLE;
      end
      FLUSH_SCAN: begin
        busy = 1'b1;
        if (dirty_q[scan_way][scan_set]) begin
          state_n = FLUSH_WB;
        end else if (scan_last) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          scan_inc = 1'b1;
        end
      end
      FLUSH_WB: begin
        busy   = 1'b1;
        mem_wr = 1'b1;
        maddr  = {tag_q[scan_way][scan_set], scan_set};
        mwdata = data_q[scan_way][scan_set];
        if (!bus.mem_busywait) begin
          flush_clr = 1'b1;
          if (scan_last) begin
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            scan_inc = 1'b1;
            state_n  = FLUSH_SCAN;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state register, victim latch and flush walk pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      scan_q   <= '0;
    end else begin
      state_q <= state_n;
      if (victim_ld) victim_q <= victim_pick;
      if (scan_clr)      scan_q <= '0;
      else if (scan_inc) scan_q <= scan_q + 1'b1;
    end
  end

  // valid, dirty and LRU bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
      for (int s = 0; s < SETS; s++) lru_q[s] <= 1'b0;
    end else begin
      if (hit_upd) begin
        lru_q[idx] <= ~hit_way;
        if (bus.C_WRITE) dirty_q[hit_way][idx] <= 1'b1;
      end
      if (fill_en) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
      if (flush_clr) dirty_q[scan_way][scan_set] <= 1'b0;
    end
  end

  // tag and data arrays: meaningful only where valid is set, so no reset
  always_ff @(posedge clock) begin
    if (hit_upd && bus.C_WRITE)
      data_q[hit_way][idx][off*DATA_W +: DATA_W] <= bus.C_WRITEDATA;
    if (fill_en) begin
      data_q[victim_q][idx] <= bus.mem_readdata;
      tag_q[victim_q][idx]  <= tag_in;
    end
  end
endmodule
